// File: rtl/ctrl_strobe_monitor_pkg.sv
// Shared definitions for the controller strobe monitor: class and error codes,
// per-phase strobe patterns, FSM state encoding and a fault-priority helper.
package ctrl_strobe_monitor_pkg;

    localparam int STB_W = 9;

    // Instruction class codes as reported on instr_class
    localparam logic [2:0] CLS_HLT  = 3'd0;
    localparam logic [2:0] CLS_SKZ  = 3'd1;
    localparam logic [2:0] CLS_LOAD = 3'd2;
    localparam logic [2:0] CLS_STO  = 3'd3;
    localparam logic [2:0] CLS_JMP  = 3'd4;
    localparam logic [2:0] CLS_NONE = 3'd7;   // class not yet committed

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_FETCH      = 3'd1;
    localparam logic [2:0] ERR_EXEC       = 3'd2;
    localparam logic [2:0] ERR_AFTER_HALT = 3'd3;
    localparam logic [2:0] ERR_SKZ_ZERO   = 3'd4;

    // Strobe vector bit order: {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}
    localparam logic [STB_W-1:0] PAT_IDLE    = 9'b000000000;
    localparam logic [STB_W-1:0] PAT_PH0     = 9'b100000000;
    localparam logic [STB_W-1:0] PAT_PH1     = 9'b110000000;
    localparam logic [STB_W-1:0] PAT_PH23    = 9'b111000000;
    localparam logic [STB_W-1:0] PAT_PH4_HLT = 9'b000110000;
    localparam logic [STB_W-1:0] PAT_PH4     = 9'b000100000;
    localparam logic [STB_W-1:0] PAT_LOAD_56 = 9'b010000000;
    localparam logic [STB_W-1:0] PAT_LOAD_7  = 9'b010000010;
    localparam logic [STB_W-1:0] PAT_STO_6   = 9'b000000100;
    localparam logic [STB_W-1:0] PAT_STO_7   = 9'b000000101;
    localparam logic [STB_W-1:0] PAT_JMP_67  = 9'b000001000;
    localparam logic [STB_W-1:0] PAT_SKIP_6  = 9'b000100000;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    // Lowest non-zero error code wins when several faults coincide
    function automatic logic [2:0] pick_err(input logic [2:0] a, input logic [2:0] b);
        if (a == ERR_NONE) return b;
        if (b == ERR_NONE) return a;
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ctrl_mon_exec_decode.sv
// Combinational pattern decoder: checks one strobe sample against the phase and
// committed class, and reports the class implied so far plus the SKZ skip bit.
module ctrl_mon_exec_decode
    import ctrl_strobe_monitor_pkg::*;
(
    input  logic [2:0]       phase,
    input  logic [2:0]       cls,
    input  logic [STB_W-1:0] strobe,
    output logic             match,
    output logic [2:0]       class_next,
    output logic             skip
);

    always_comb begin
        match      = 1'b0;
        class_next = cls;
        skip       = 1'b0;
        case (phase)
            3'd0: begin
                match      = (strobe == PAT_PH0);
                class_next = CLS_NONE;
            end
            3'd1: begin
                match      = (strobe == PAT_PH1);
                class_next = CLS_NONE;
            end
            3'd2, 3'd3: begin
                match      = (strobe == PAT_PH23);
                class_next = CLS_NONE;
            end
            3'd4: begin
                if (strobe == PAT_PH4_HLT) begin
                    match      = 1'b1;
                    class_next = CLS_HLT;
                end else if (strobe == PAT_PH4) begin
                    match      = 1'b1;
                    class_next = CLS_NONE;
                end
            end
            3'd5: begin
                if (cls == CLS_HLT) begin
                    match = (strobe == PAT_IDLE);
                end else if (strobe == PAT_LOAD_56) begin
                    match      = 1'b1;
                    class_next = CLS_LOAD;
                end else if (strobe == PAT_IDLE) begin
                    match = 1'b1;
                end
            end
            3'd6: begin
                case (cls)
                    CLS_HLT:  match = (strobe == PAT_IDLE);
                    CLS_LOAD: match = (strobe == PAT_LOAD_56);
                    default: begin
                        // Non-LOAD, non-HLT classes only become distinguishable here
                        if (strobe == PAT_IDLE) begin
                            match      = 1'b1;
                            class_next = CLS_SKZ;
                        end else if (strobe == PAT_SKIP_6) begin
                            match      = 1'b1;
                            class_next = CLS_SKZ;
                            skip       = 1'b1;
                        end else if (strobe == PAT_STO_6) begin
                            match      = 1'b1;
                            class_next = CLS_STO;
                        end else if (strobe == PAT_JMP_67) begin
                            match      = 1'b1;
                            class_next = CLS_JMP;
                        end
                    end
                endcase
            end
            default: begin
                case (cls)
                    CLS_HLT, CLS_SKZ: match = (strobe == PAT_IDLE);
                    CLS_LOAD:         match = (strobe == PAT_LOAD_7);
                    CLS_STO:          match = (strobe == PAT_STO_7);
                    CLS_JMP:          match = (strobe == PAT_JMP_67);
                    default:          match = 1'b0;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/ctrl_strobe_monitor.sv
// Passive monitor inferring the 8-phase instruction cycle from controller strobes.
// Optional retired-instruction counter is built when CTRL_MON_COUNT_EN is defined.
module ctrl_strobe_monitor
    import ctrl_strobe_monitor_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             rd,
    input  logic             ld_ir,
    input  logic             inc_pc,
    input  logic             halt,
    input  logic             ld_pc,
    input  logic             data_e,
    input  logic             ld_ac,
    input  logic             wr,
    input  logic             zero,
    output logic             instr_valid,
    output logic [2:0]       instr_class,
    output logic             skip_taken,
    output logic             err,
    output logic [2:0]       err_code,
    output logic             halted,
    output logic             synced,
    output logic [CNT_W-1:0] instr_count
);

    logic [STB_W-1:0] strobe;
    assign strobe = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

    state_t     state_reg, state_next;
    logic [2:0] phase_reg, phase_next;
    logic [2:0] cls_reg, cls_next;
    logic       skip_reg, skip_next;
    logic       halt_err_reg, halt_err_next;

    logic       instr_valid_reg, instr_valid_next;
    logic [2:0] instr_class_reg, instr_class_next;
    logic       skip_taken_reg, skip_taken_next;
    logic       err_reg, err_next;
    logic [2:0] err_code_reg, err_code_next;
    logic       halted_reg, halted_next;
    logic       synced_reg, synced_next;

    logic       dec_match;
    logic [2:0] dec_class;
    logic       dec_skip;
    logic [2:0] match_fault, skz_fault, fault;

    ctrl_mon_exec_decode u_decode (
        .phase      (phase_reg),
        .cls        (cls_reg),
        .strobe     (strobe),
        .match      (dec_match),
        .class_next (dec_class),
        .skip       (dec_skip)
    );

    // A bad ph4 sample means the fetch never delivered a valid opcode
    assign match_fault = dec_match ? ERR_NONE
                       : ((phase_reg <= 3'd4) ? ERR_FETCH : ERR_EXEC);
    assign skz_fault   = (dec_match && phase_reg == 3'd6 && dec_class == CLS_SKZ
                          && (zero != dec_skip)) ? ERR_SKZ_ZERO : ERR_NONE;
    assign fault       = pick_err(match_fault, skz_fault);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_SYNC;
            phase_reg       <= 3'd0;
            cls_reg         <= CLS_NONE;
            skip_reg        <= 1'b0;
            halt_err_reg    <= 1'b0;
            instr_valid_reg <= 1'b0;
            instr_class_reg <= 3'd0;
            skip_taken_reg  <= 1'b0;
            err_reg         <= 1'b0;
            err_code_reg    <= ERR_NONE;
            halted_reg      <= 1'b0;
            synced_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            phase_reg       <= phase_next;
            cls_reg         <= cls_next;
            skip_reg        <= skip_next;
            halt_err_reg    <= halt_err_next;
            instr_valid_reg <= instr_valid_next;
            instr_class_reg <= instr_class_next;
            skip_taken_reg  <= skip_taken_next;
            err_reg         <= err_next;
            err_code_reg    <= err_code_next;
            halted_reg      <= halted_next;
            synced_reg      <= synced_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        phase_next       = phase_reg;
        cls_next         = cls_reg;
        skip_next        = skip_reg;
        halt_err_next    = halt_err_reg;
        instr_valid_next = 1'b0;
        instr_class_next = instr_class_reg;
        skip_taken_next  = 1'b0;
        err_next         = 1'b0;
        err_code_next    = err_code_reg;
        halted_next      = halted_reg;
        synced_next      = synced_reg;

        case (state_reg)
            ST_SYNC: begin
                // phase_reg is held at 0 here, so the decoder checks for a ph0 pattern
                if (dec_match) begin
                    state_next  = ST_FETCH;
                    phase_next  = 3'd1;
                    cls_next    = CLS_NONE;
                    skip_next   = 1'b0;
                    synced_next = 1'b1;
                end
            end
            ST_FETCH, ST_EXEC: begin
                if (fault != ERR_NONE) begin
                    err_next      = 1'b1;
                    err_code_next = fault;
                    state_next    = ST_SYNC;
                    phase_next    = 3'd0;
                    cls_next      = CLS_NONE;
                    skip_next     = 1'b0;
                    synced_next   = 1'b0;
                end else if (phase_reg == 3'd7) begin
                    instr_valid_next = 1'b1;
                    instr_class_next = cls_reg;
                    skip_taken_next  = skip_reg && (cls_reg == CLS_SKZ);
                    phase_next       = 3'd0;
                    cls_next         = CLS_NONE;
                    skip_next        = 1'b0;
                    if (cls_reg == CLS_HLT) begin
                        state_next  = ST_HALTED;
                        halted_next = 1'b1;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end else begin
                    phase_next = phase_reg + 3'd1;
                    state_next = (phase_reg >= 3'd3) ? ST_EXEC : ST_FETCH;
                    cls_next   = dec_class;
                    if (phase_reg == 3'd6) begin
                        skip_next = dec_skip;
                    end
                end
            end
            ST_HALTED: begin
                // Only the first activity after a halt is reported
                if (strobe != PAT_IDLE && !halt_err_reg) begin
                    err_next      = 1'b1;
                    err_code_next = ERR_AFTER_HALT;
                    halt_err_next = 1'b1;
                    synced_next   = 1'b0;
                end
            end
            default: begin
                state_next = ST_SYNC;
                phase_next = 3'd0;
            end
        endcase
    end

    assign instr_valid = instr_valid_reg;
    assign instr_class = instr_class_reg;
    assign skip_taken  = skip_taken_reg;
    assign err         = err_reg;
    assign err_code    = err_code_reg;
    assign halted      = halted_reg;
    assign synced      = synced_reg;

`ifdef CTRL_MON_COUNT_EN
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (instr_valid_next) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign instr_count = count_reg;
`else
    assign instr_count = '0;
`endif

endmodule
